high_score_ctrl: RTL and testbench

Per-user best-score table controller for the SegmentRunner game. It owns a small internal score memory and sequences all access to it. The game controller submits the final score at game end through an update port; the display/menu logic reads a user's best score through a query port. The block arbitrates between the two ports and a bulk-clear command, so the single-port memory never sees conflicting accesses.

---
 rtl/high_score_ctrl.sv | 129 ++++++++++++
 tb/tb_high_score_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/high_score_ctrl.sv
// high_score_ctrl: per-user best-score table with update/query arbitration and bulk clear
module high_score_ctrl #(
  parameter int NUM_USERS = 8,
  parameter int USER_W    = 3,
  parameter int SCORE_W   = 14,
  parameter int SCORE_MAX = 9999
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               UpdReq,
  input  logic [USER_W-1:0]  UpdUser,
  input  logic [SCORE_W-1:0] UpdScore,
  output logic               UpdAck,
  output logic               NewRecord,
  input  logic               QryReq,
  input  logic [USER_W-1:0]  QryUser,
  output logic               QryAck,
  output logic [SCORE_W-1:0] QryScore,
  input  logic               ClearAll,
  output logic               Busy
);
  localparam int AW = $clog2(NUM_USERS);
  localparam logic [AW-1:0] LAST = AW'(NUM_USERS - 1);
  localparam logic [USER_W:0] N_USERS = (USER_W + 1)'(NUM_USERS);
  localparam logic [SCORE_W-1:0] SMAX = SCORE_W'(SCORE_MAX);
  typedef enum logic [2:0] {IDLE, CLR, Q_READ, Q_RESP, U_READ, U_CMP, U_RESP} state_t;
  state_t state_q, state_d;
  logic [SCORE_W-1:0] mem_q [NUM_USERS];
  logic [SCORE_W-1:0] rd_q, rd_d, score_q, score_d, qry_score_q, qry_score_d, wdata, clamped;
  logic [USER_W-1:0] user_q, user_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d, addr;
  logic pend_q, pend_d, last_upd_q, last_upd_d, rec_q, rec_d, we, in_range;
  assign addr = (state_q == CLR) ? clr_idx_q : user_q[AW-1:0];
  assign in_range = {1'b0, user_q} < N_USERS;
  assign clamped = (score_q > SMAX) ? SMAX : score_q;
  always_comb begin
    state_d = state_q;
    clr_idx_d = clr_idx_q;
    pend_d = pend_q | (ClearAll && state_q != IDLE);
    last_upd_d = last_upd_q;
    user_d = user_q;
    score_d = score_q;
    qry_score_d = qry_score_q;
    rec_d = rec_q;
    rd_d = rd_q;
    we = 1'b0;
    wdata = '0;
    case (state_q)
      IDLE: begin
        if (ClearAll || pend_q) begin
          state_d = CLR;
          pend_d = 1'b0;
          clr_idx_d = '0;
        end else if (UpdReq && (!QryReq || !last_upd_q)) begin
          state_d = U_READ;
          user_d = UpdUser;
          score_d = UpdScore;
          last_upd_d = QryReq ? 1'b1 : last_upd_q;
        end else if (QryReq) begin
          state_d = Q_READ;
          user_d = QryUser;
          last_upd_d = UpdReq ? 1'b0 : last_upd_q;
        end
      end
      CLR: begin
        we = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        state_d = (clr_idx_q == LAST) ? IDLE : CLR;
      end
      Q_READ: begin
        rd_d = in_range ? mem_q[addr] : '0;
        state_d = Q_RESP;
      end
      Q_RESP: begin
        qry_score_d = rd_q;
        state_d = IDLE;
      end
      U_READ: begin
        rd_d = in_range ? mem_q[addr] : '0;
        state_d = U_CMP;
      end
      U_CMP: begin
        we = in_range && (clamped > rd_q);
        wdata = clamped;
        rec_d = we;
        state_d = U_RESP;
      end
      U_RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A clear requested mid-transaction runs straight after the transaction retires
    if (state_q != IDLE && state_d == IDLE && pend_d) begin
      state_d = CLR;
      pend_d = 1'b0;
      clr_idx_d = '0;
    end
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= CLR;
      clr_idx_q <= '0;
      pend_q <= 1'b0;
      last_upd_q <= 1'b0;
      user_q <= '0;
      score_q <= '0;
      qry_score_q <= '0;
      rec_q <= 1'b0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      clr_idx_q <= clr_idx_d;
      pend_q <= pend_d;
      last_upd_q <= last_upd_d;
      user_q <= user_d;
      score_q <= score_d;
      qry_score_q <= qry_score_d;
      rec_q <= rec_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge Clk) begin
    if (we) mem_q[addr] <= wdata;
  end
  assign UpdAck = (state_q == U_RESP);
  assign NewRecord = (state_q == U_RESP) && rec_q;
  assign QryAck = (state_q == Q_RESP);
  assign QryScore = (state_q == Q_RESP) ? rd_q : qry_score_q;
  assign Busy = (state_q != IDLE);
endmodule

// File: tb/tb_high_score_ctrl.sv
// tb_high_score_ctrl: directed scenario bench for high_score_ctrl (USER_W widened to 4 to reach index 9)
module tb_high_score_ctrl;
  localparam int UW = 4;
  localparam int SW = 14;
  logic Clk = 1'b0, Rst = 1'b1, UpdReq = 1'b0, QryReq = 1'b0, ClearAll = 1'b0;
  logic [UW-1:0] UpdUser = '0, QryUser = '0;
  logic [SW-1:0] UpdScore = '0;
  logic UpdAck, NewRecord, QryAck, Busy;
  logic [SW-1:0] QryScore;
  int errors = 0, checks = 0;

  always #5 Clk = ~Clk;

  high_score_ctrl #(.NUM_USERS(8), .USER_W(UW), .SCORE_W(SW), .SCORE_MAX(9999)) dut (
    .Clk(Clk), .Rst(Rst), .UpdReq(UpdReq), .UpdUser(UpdUser), .UpdScore(UpdScore),
    .UpdAck(UpdAck), .NewRecord(NewRecord), .QryReq(QryReq), .QryUser(QryUser),
    .QryAck(QryAck), .QryScore(QryScore), .ClearAll(ClearAll), .Busy(Busy)
  );

  task automatic do_query(input logic [UW-1:0] u, output logic [SW-1:0] s, output int lat);
    QryUser = u;
    QryReq = 1'b1;
    lat = -1;
    s = '1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      if (QryAck) begin
        lat = i;
        s = QryScore;
        break;
      end
    end
    QryReq = 1'b0;
    @(negedge Clk);
  endtask

  task automatic do_update(input logic [UW-1:0] u, input logic [SW-1:0] sc, output logic rec, output int lat);
    UpdUser = u;
    UpdScore = sc;
    UpdReq = 1'b1;
    lat = -1;
    rec = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      if (UpdAck) begin
        lat = i;
        rec = NewRecord;
        break;
      end
    end
    UpdReq = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    int n;
    @(negedge Clk);
    checks += 5;
    if (Busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b want 1", Busy); end
    if (UpdAck !== 1'b0) begin errors++; $display("FAIL rst_updack got %b want 0", UpdAck); end
    if (NewRecord !== 1'b0) begin errors++; $display("FAIL rst_newrec got %b want 0", NewRecord); end
    if (QryAck !== 1'b0) begin errors++; $display("FAIL rst_qryack got %b want 0", QryAck); end
    if (QryScore !== '0) begin errors++; $display("FAIL rst_qryscore got %0d want 0", QryScore); end
    Rst = 1'b0;
    n = 0;
    while (Busy && n < 30) begin
      n++;
      @(negedge Clk);
    end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL rst_busy_cycles got %0d want 8", n); end
  endtask

  task automatic test_query_empty();
    logic [SW-1:0] s;
    int lat;
    do_query(3, s, lat);
    checks += 2;
    if (lat !== 2) begin errors++; $display("FAIL qry3_latency got %0d want 2", lat); end
    if (s !== 14'd0) begin errors++; $display("FAIL qry3_score got %0d want 0", s); end
  endtask

  task automatic test_update_basic();
    logic rec;
    int lat;
    logic [SW-1:0] s;
    do_update(2, 150, rec, lat);
    checks += 2;
    if (lat !== 3) begin errors++; $display("FAIL upd2_latency got %0d want 3", lat); end
    if (rec !== 1'b1) begin errors++; $display("FAIL upd2_150_rec got %b want 1", rec); end
    do_update(2, 150, rec, lat);
    checks += 2;
    if (lat !== 3) begin errors++; $display("FAIL upd2_eq_latency got %0d want 3", lat); end
    if (rec !== 1'b0) begin errors++; $display("FAIL upd2_eq_rec got %b want 0", rec); end
    do_update(2, 120, rec, lat);
    checks++;
    if (rec !== 1'b0) begin errors++; $display("FAIL upd2_120_rec got %b want 0", rec); end
    do_query(2, s, lat);
    checks++;
    if (s !== 14'd150) begin errors++; $display("FAIL qry2_score got %0d want 150", s); end
    checks++;
    if (QryScore !== 14'd150) begin errors++; $display("FAIL qry2_hold got %0d want 150", QryScore); end
  endtask

  task automatic test_saturate();
    logic rec;
    int lat;
    logic [SW-1:0] s;
    do_update(5, 16000, rec, lat);
    checks++;
    if (rec !== 1'b1) begin errors++; $display("FAIL upd5_sat_rec got %b want 1", rec); end
    do_query(5, s, lat);
    checks++;
    if (s !== 14'd9999) begin errors++; $display("FAIL qry5_sat got %0d want 9999", s); end
  endtask

  task automatic test_tie(input logic exp_upd_first, input logic [UW-1:0] uu, input logic [SW-1:0] us,
                          input logic exp_rec, input logic [UW-1:0] qu, input logic [SW-1:0] exp_s);
    logic got_u, got_q, first_upd, rec;
    logic [SW-1:0] s;
    got_u = 1'b0; got_q = 1'b0; first_upd = 1'b0; rec = 1'bx; s = '1;
    UpdUser = uu; UpdScore = us; QryUser = qu;
    UpdReq = 1'b1; QryReq = 1'b1;
    for (int i = 0; i < 40 && !(got_u && got_q); i++) begin
      @(negedge Clk);
      if (UpdAck) begin
        if (!got_q) first_upd = 1'b1;
        got_u = 1'b1;
        rec = NewRecord;
        UpdReq = 1'b0;
      end
      if (QryAck) begin
        got_q = 1'b1;
        s = QryScore;
        QryReq = 1'b0;
      end
    end
    UpdReq = 1'b0; QryReq = 1'b0;
    @(negedge Clk);
    checks += 4;
    if ((got_u && got_q) !== 1'b1) begin errors++; $display("FAIL tie_both_acked got u=%b q=%b want 1 1", got_u, got_q); end
    if (first_upd !== exp_upd_first) begin errors++; $display("FAIL tie_order got upd_first=%b want %b", first_upd, exp_upd_first); end
    if (rec !== exp_rec) begin errors++; $display("FAIL tie_rec got %b want %b", rec, exp_rec); end
    if (s !== exp_s) begin errors++; $display("FAIL tie_qry_score got %0d want %0d", s, exp_s); end
  endtask

  task automatic test_clear_mid_update();
    int n, lat;
    logic [SW-1:0] s;
    UpdUser = 1; UpdScore = 300; UpdReq = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    ClearAll = 1'b1;
    @(negedge Clk);
    ClearAll = 1'b0;
    checks += 2;
    if (UpdAck !== 1'b1) begin errors++; $display("FAIL clr_updack got %b want 1", UpdAck); end
    if (NewRecord !== 1'b1) begin errors++; $display("FAIL clr_newrec got %b want 1", NewRecord); end
    UpdReq = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      if (!Busy) break;
      n++;
    end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL clr_busy_cycles got %0d want 8", n); end
    do_query(1, s, lat);
    checks += 2;
    if (lat !== 2) begin errors++; $display("FAIL clr_qry1_latency got %0d want 2", lat); end
    if (s !== 14'd0) begin errors++; $display("FAIL clr_qry1_score got %0d want 0", s); end
  endtask

  task automatic test_out_of_range();
    logic rec;
    int lat;
    logic [SW-1:0] s;
    do_update(9, 500, rec, lat);
    checks += 2;
    if (lat !== 3) begin errors++; $display("FAIL oor_upd_latency got %0d want 3", lat); end
    if (rec !== 1'b0) begin errors++; $display("FAIL oor_upd_rec got %b want 0", rec); end
    do_query(9, s, lat);
    checks += 2;
    if (lat !== 2) begin errors++; $display("FAIL oor_qry_latency got %0d want 2", lat); end
    if (s !== 14'd0) begin errors++; $display("FAIL oor_qry_score got %0d want 0", s); end
    do_query(1, s, lat);
    checks++;
    if (s !== 14'd0) begin errors++; $display("FAIL oor_alias_qry1 got %0d want 0", s); end
  endtask

  task automatic test_reset_mid_query();
    logic rec, seen_ack;
    int lat, n;
    logic [SW-1:0] s;
    do_update(4, 44, rec, lat);
    checks++;
    if (rec !== 1'b1) begin errors++; $display("FAIL rq_upd4_rec got %b want 1", rec); end
    QryUser = 4; QryReq = 1'b1;
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    QryReq = 1'b0;
    seen_ack = 1'b0;
    n = 0;
    while (Busy && n < 30) begin
      if (QryAck) seen_ack = 1'b1;
      n++;
      @(negedge Clk);
    end
    checks += 2;
    if (seen_ack !== 1'b0) begin errors++; $display("FAIL rq_no_ack got %b want 0", seen_ack); end
    if (n !== 8) begin errors++; $display("FAIL rq_clear_cycles got %0d want 8", n); end
    do_query(4, s, lat);
    checks++;
    if (s !== 14'd0) begin errors++; $display("FAIL rq_qry4_score got %0d want 0", s); end
  endtask

  initial begin
    test_reset();
    test_query_empty();
    test_update_basic();
    test_saturate();
    test_tie(1'b1, 0, 10, 1'b1, 2, 150);
    test_tie(1'b0, 0, 10, 1'b0, 0, 10);
    test_clear_mid_update();
    test_out_of_range();
    test_reset_mid_query();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
